// File: rtl/shift_right_seq.sv
// Sequential lane right shifter: moves a 96-bit word down one 12-bit lane per cycle, filling the top.
// Optional build macro SHIFT_RIGHT_LANE_EXT_EN: vacated lanes replicate source lane 7 instead of the fill port.
module shift_right_seq #(
  parameter int LANE_W    = 12,
  parameter int LANES     = 8,
  parameter int MAX_SHIFT = 5,
  parameter int SHIFT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic [LANE_W-1:0]         fill,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out,
  output logic                      out_err
);

  localparam int W = LANES * LANE_W;
  localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(MAX_SHIFT);
  localparam logic [SHIFT_W-1:0] ONE_S = SHIFT_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        data_q;
  logic [LANE_W-1:0]   fill_q;
  logic [SHIFT_W-1:0]  cnt_q;
  logic                err_q;
  logic                accept;
  logic                illegal;
  logic                no_shift;
  logic [LANE_W-1:0]   fill_src;

  assign accept   = in_valid && in_ready;
  assign illegal  = shift > MAX_S;
  assign no_shift = shift == '0;

`ifdef SHIFT_RIGHT_LANE_EXT_EN
  assign fill_src = in[W-1 -: LANE_W];
`else
  assign fill_src = fill;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (illegal || no_shift) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_q == ONE_S) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out       = data_q;
    out_err   = err_q;
  end

  // Illegal amounts skip the shift phase and report an all-zero word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q <= illegal ? '0 : in;
            fill_q <= fill_src;
            cnt_q  <= shift;
            err_q  <= illegal;
          end
        end
        SHIFT: begin
          data_q <= {fill_q, data_q[W-1:LANE_W]};
          cnt_q  <= cnt_q - ONE_S;
        end
        DONE: begin
          if (out_ready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Sequential lane-granular right shifter. Companion to the combinational lane shift-left unit: it undoes a left lane shift.
- Data word is 8 lanes of 12 bits. Each cycle the word moves down by one lane. Vacated top lanes take a fill value.
- Valid/ready on both sides. Sits on the unpack side of the lane datapath, after the shift-left packer.

Parameters:
- LANE_W, 12, bits per lane
- LANES, 8, lanes per word; word width = LANES*LANE_W = 96
- MAX_SHIFT, 5, largest legal shift; larger amounts are rejected with out_err
- SHIFT_W, 3, width of the shift amount port

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in  input  96  source word; lane k = in[12k+11:12k]
- shift  input  3  right shift amount, in lanes
- fill  input  12  value written into each vacated top lane
- out_valid  output  1  result held on out/out_err
- out_ready  input  1  consumer takes the result
- out  output  96  shifted word
- out_err  output  1  shift amount was illegal (>MAX_SHIFT)

Behaviour:
- Reset: state IDLE; out=0, out_err=0, out_valid=0, in_ready=1. Reset mid-operation drops the pending request with no output.
- States and transitions:
  - IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture in into data_q, fill into fill_q, shift into cnt_q, then:
    - shift 1..MAX_SHIFT: go to SHIFT.
    - shift 0: go to DONE, data_q=in, out_err=0.
    - shift >MAX_SHIFT (6 or 7): go to DONE, data_q=0, out_err=1.
  - SHIFT: in_ready=0, out_valid=0. Each edge: data_q <= {fill_q, data_q[95:12]} and cnt_q <= cnt_q-1. When cnt_q==1 at the edge, go to DONE.
  - DONE: out_valid=1, in_ready=0. out = data_q and out_err are held stable until out_ready. On out_valid&&out_ready, go to IDLE and clear out_err.
- Result: out lane i = in lane (i+s) for i+s<8, else fill.
- Latency: out_valid rises s+1 edges after the accept edge, for legal s. Illegal shift gives latency 1.
- Throughput: one request per s+2 cycles minimum. in_ready is low from the accept edge until the handshake edge in DONE. There is no overlap of DONE with a new accept.
- in_valid while busy is ignored; in, shift and fill are sampled only at the accept edge.
- fill is sampled once per request. Later changes on the fill port do not affect a result in flight.
- out_ready held low: DONE persists indefinitely with out stable.
- out_ready high on entry to DONE: out_valid is high for exactly one cycle.

Optional Feature:
- SHIFT_RIGHT_LANE_EXT_EN
- Defined: at accept, fill_q is loaded with the source word's top lane (in[95:84]) instead of the fill port. Vacated lanes replicate lane 7 (lane-wise sign extension). The fill port is still present but ignored.
- Undefined: fill_q comes from the fill port as described above.
- out_err behaviour is identical in both builds.

Test Plan:
- Reset, then request with lane k = 12'hA00+k, shift=2, fill=12'hFFF, out_ready=1 -> out_valid 3 edges after accept; out lanes 7..0 = FFF,FFF,A07,A06,A05,A04,A03,A02; out_err=0; in_ready back to 1 on the next cycle.
- Same input, shift=0 -> out_valid 1 edge after accept; out == in; out_err=0.
- Same input, shift=5, fill=12'h123, out_ready held 0 for 4 cycles -> lanes 7..3 = 123, lanes 2..0 = A07,A06,A05; out stable and in_ready=0 throughout; one handshake when out_ready rises.
- shift=6, then shift=7 -> each gives out=0, out_err=1 after 1 edge; next request with shift=1 gives out_err=0 and lane0=A01.
- Accept with shift=4, assert rst for 1 cycle at cycle 2 -> out_valid stays 0, out=0, in_ready=1 after reset; a second in_valid pulse while in SHIFT is not accepted.
- Build with SHIFT_RIGHT_LANE_EXT_EN, lane7=12'h8AB, shift=3, fill=12'h000 -> lanes 7..5 = 8AB; lanes 4..0 = source lanes 7..3.
